// File: rtl/cv32e40p_lsu_wb_pair_if.sv
// LSU load-request / response bus and register-file W2 (port B) write bus
// for the load write-back sequencer.
interface cv32e40p_lsu_wb_pair_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_waddr_i;
  logic                  req_is64_i;
  logic                  rvalid_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic [DATA_WIDTH-1:0] wdata_b1_o;
  logic                  instr64_oe_o;
  logic                  pending_o;
  logic                  err_o;

  // LSU / register-file side.
  modport master (
    output req_valid_i, req_waddr_i, req_is64_i, rvalid_i, rdata_i,
    input  req_ready_o, we_b_o, waddr_b_o, wdata_b_o, wdata_b1_o,
           instr64_oe_o, pending_o, err_o
  );

  // Sequencer side.
  modport slave (
    input  req_valid_i, req_waddr_i, req_is64_i, rvalid_i, rdata_i,
    output req_ready_o, we_b_o, waddr_b_o, wdata_b_o, wdata_b1_o,
           instr64_oe_o, pending_o, err_o
  );
endinterface

// File: rtl/cv32e40p_lsu_wb_pair.sv
// Load write-back sequencer: in-order tag FIFO plus beat FSM that merges 64-bit
// loads into paired W2 writes. Define CV32E40P_LSU_WB_PAIR_OREG_EN to register the W2/err outputs.
//
// state   | meaning
// ST_LOW  | waiting for the first (or only) beat of the head entry
// ST_HIGH | low word of a 64-bit head held in lo_q, waiting for the high beat
module cv32e40p_lsu_wb_pair #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  cv32e40p_lsu_wb_pair_if.slave    bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_mem [DEPTH];
  logic                  is64_mem  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic [DATA_WIDTH-1:0] lo_q;

  logic                  full, empty, ready, push, pop, beat;
  logic [ADDR_WIDTH-1:0] head_waddr;
  logic                  head_is64;
  logic                  wr_en, pair, err_c, lo_latch;
  logic [ADDR_WIDTH-1:0] w_addr_c;
  logic [DATA_WIDTH-1:0] w_data_c, w_data1_c;

  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_waddr = waddr_mem[rd_ptr_q];
  assign head_is64  = is64_mem[rd_ptr_q];

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign ready = !rst && !full;
  assign push  = bus.req_valid_i && ready;
  assign beat  = bus.rvalid_i && !rst;
  assign pop   = beat && !empty && ((state_q == ST_HIGH) || !head_is64);

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_mem[wr_ptr_q] <= bus.req_waddr_i;
      is64_mem[wr_ptr_q]  <= bus.req_is64_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (lo_latch) lo_q <= bus.rdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    pair     = 1'b0;
    err_c    = 1'b0;
    lo_latch = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (beat) begin
          if (empty) begin
            err_c = 1'b1;
          end else if (head_is64) begin
            lo_latch = 1'b1;
            state_d  = ST_HIGH;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (beat) begin
          state_d = ST_LOW;
          // Odd base would spill waddr+1 across a bank boundary (x31/f31).
          if (head_waddr[0]) begin
            err_c = 1'b1;
          end else begin
            wr_en = 1'b1;
            pair  = 1'b1;
          end
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  assign w_addr_c  = wr_en ? head_waddr : '0;
  assign w_data_c  = !wr_en ? '0 : (pair ? lo_q : bus.rdata_i);
  assign w_data1_c = pair ? bus.rdata_i : '0;

`ifdef CV32E40P_LSU_WB_PAIR_OREG_EN
  logic                  we_q, pair_q, err_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      pair_q   <= 1'b0;
      err_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wdata1_q <= '0;
    end else begin
      we_q     <= wr_en;
      pair_q   <= pair;
      err_q    <= err_c;
      waddr_q  <= w_addr_c;
      wdata_q  <= w_data_c;
      wdata1_q <= w_data1_c;
    end
  end

  assign bus.we_b_o       = we_q;
  assign bus.instr64_oe_o = pair_q;
  assign bus.err_o        = err_q;
  assign bus.waddr_b_o    = waddr_q;
  assign bus.wdata_b_o    = wdata_q;
  assign bus.wdata_b1_o   = wdata1_q;
  assign bus.pending_o    = !rst && (!empty || we_q);
`else
  assign bus.we_b_o       = wr_en;
  assign bus.instr64_oe_o = pair;
  assign bus.err_o        = err_c;
  assign bus.waddr_b_o    = w_addr_c;
  assign bus.wdata_b_o    = w_data_c;
  assign bus.wdata_b1_o   = w_data1_c;
  assign bus.pending_o    = !rst && !empty;
`endif

  assign bus.req_ready_o = ready;

endmodule
